// File: rtl/dmem_pkg.sv
// Shared definitions for the data memory unit: MIPS load/store opcodes, FSM states, access sizes.
package dmem_pkg;

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2B;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  typedef enum logic [1:0] {BYTE, HALF, WORD} size_t;

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational opcode decode, store byte-enable/lane replication, load extraction/extension
// and misalignment detection for one 32-bit little-endian word.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [5:0]  opcode,
  input  logic [1:0]  offset,
  input  logic [31:0] store_data,
  input  logic [31:0] mem_word,
  output logic        is_load,
  output logic        is_store,
  output logic        misaligned,
  output logic [3:0]  byte_en,
  output logic [31:0] store_word,
  output logic [31:0] load_data
);

  size_t       size;
  logic        sign_ext;
  logic [31:0] shifted;

  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    size     = WORD;
    sign_ext = 1'b0;
    case (opcode)
      OP_LB:   begin is_load  = 1'b1; size = BYTE; sign_ext = 1'b1; end
      OP_LH:   begin is_load  = 1'b1; size = HALF; sign_ext = 1'b1; end
      OP_LW:   begin is_load  = 1'b1; size = WORD; end
      OP_LBU:  begin is_load  = 1'b1; size = BYTE; end
      OP_LHU:  begin is_load  = 1'b1; size = HALF; end
      OP_SB:   begin is_store = 1'b1; size = BYTE; end
      OP_SH:   begin is_store = 1'b1; size = HALF; end
      OP_SW:   begin is_store = 1'b1; size = WORD; end
      default: ;
    endcase
  end

  always_comb begin
    misaligned = ((size == HALF) && offset[0]) || ((size == WORD) && (offset != 2'b00));
    byte_en    = 4'hF;
    store_word = store_data;
    load_data  = mem_word;
    shifted    = mem_word >> {offset, 3'b000};
    case (size)
      BYTE: begin
        byte_en    = 4'b0001 << offset;
        store_word = {4{store_data[7:0]}};
        load_data  = {{24{sign_ext & shifted[7]}}, shifted[7:0]};
      end
      HALF: begin
        byte_en    = 4'b0011 << offset;
        store_word = {2{store_data[15:0]}};
        load_data  = {{16{sign_ext & shifted[15]}}, shifted[15:0]};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/data_mem_unit.sv
// Request/response data memory with fixed LATENCY, byte/half/word loads and stores.
// Optional statistics counters built only when DMEM_STATS_EN is defined.
module data_mem_unit
  import dmem_pkg::*;
#(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] address,
  input  logic [31:0] DataWrite,
  input  logic [5:0]  opcode,
  input  logic        MemRead,
  input  logic        MemWrite,
  output logic        rsp_valid,
  output logic [31:0] ReadData,
  output logic        err,
  output logic        stall,
  output logic [15:0] rd_cnt,
  output logic [15:0] wr_cnt,
  output logic [15:0] err_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt;
  logic            wait_done, resolve, commit, err_nxt;
  logic [AW+1:0]   addr_q;
  logic [31:0]     wdata_q;
  logic [5:0]      op_q;
  logic            rd_q, wr_q;
  logic            is_load, is_store, misaligned;
  logic [3:0]      byte_en;
  logic [31:0]     store_word, load_data;
  logic            unused_addr;

  logic [31:0] mem [DEPTH] = '{default: '0};

  assign unused_addr = ^address[31:AW+2];

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign stall     = req_valid & ~rsp_valid;
  assign wait_done = (cnt == CW'(LATENCY - 1));
  assign resolve   = (state == WAIT) && wait_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state == WAIT && !wait_done) cnt <= cnt + 1'b1;
      else                             cnt <= '0;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_valid) state_nxt = WAIT;
      WAIT:    if (wait_done) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      op_q    <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
    end else if (req_valid && req_ready) begin
      addr_q  <= address[AW+1:0];
      wdata_q <= DataWrite;
      op_q    <= opcode;
      rd_q    <= MemRead;
      wr_q    <= MemWrite;
    end
  end

  dmem_lane_align u_align (
    .opcode     (op_q),
    .offset     (addr_q[1:0]),
    .store_data (wdata_q),
    .mem_word   (mem[addr_q[AW+1:2]]),
    .is_load    (is_load),
    .is_store   (is_store),
    .misaligned (misaligned),
    .byte_en    (byte_en),
    .store_word (store_word),
    .load_data  (load_data)
  );

  // A no-op (both strobes low) never flags, whatever the opcode says.
  assign err_nxt = (rd_q & wr_q) | (rd_q & ~is_load) | (wr_q & ~is_store)
                 | ((rd_q | wr_q) & misaligned);
  assign commit  = resolve & wr_q & ~err_nxt;

  always_ff @(posedge clk) begin
    if (!rst && commit) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en[i]) mem[addr_q[AW+1:2]][8*i +: 8] <= store_word[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ReadData <= '0;
      err      <= 1'b0;
    end else if (resolve) begin
      ReadData <= (rd_q && !err_nxt) ? load_data : '0;
      err      <= err_nxt;
    end
  end

`ifdef DMEM_STATS_EN
  logic [15:0] rd_cnt_q, wr_cnt_q, err_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_cnt_q  <= '0;
      wr_cnt_q  <= '0;
      err_cnt_q <= '0;
    end else if (state == RESP) begin
      if (err) begin
        if (err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 1'b1;
      end else if (rd_q && !wr_q) begin
        if (rd_cnt_q != 16'hFFFF) rd_cnt_q <= rd_cnt_q + 1'b1;
      end else if (wr_q && !rd_q) begin
        if (wr_cnt_q != 16'hFFFF) wr_cnt_q <= wr_cnt_q + 1'b1;
      end
    end
  end

  assign rd_cnt  = rd_cnt_q;
  assign wr_cnt  = wr_cnt_q;
  assign err_cnt = err_cnt_q;
`else
  assign rd_cnt  = '0;
  assign wr_cnt  = '0;
  assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_data_mem_unit.sv
// Directed self-checking bench for data_mem_unit (DEPTH=256, LATENCY=2).
module tb_data_mem_unit;
  import dmem_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] address;
  logic [31:0] DataWrite;
  logic [5:0]  opcode;
  logic        MemRead;
  logic        MemWrite;
  logic        rsp_valid;
  logic [31:0] ReadData;
  logic        err;
  logic        stall;
  logic [15:0] rd_cnt, wr_cnt, err_cnt;

  int n_chk  = 0;
  int n_pass = 0;
  int exp_rd = 0, exp_wr = 0, exp_er = 0;

  always #5 clk = ~clk;

  data_mem_unit #(.DEPTH(256), .LATENCY(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .address   (address),
    .DataWrite (DataWrite),
    .opcode    (opcode),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .rsp_valid (rsp_valid),
    .ReadData  (ReadData),
    .err       (err),
    .stall     (stall),
    .rd_cnt    (rd_cnt),
    .wr_cnt    (wr_cnt),
    .err_cnt   (err_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
  endtask

  task automatic check_counters(input string tag);
`ifdef DMEM_STATS_EN
    check({tag, ".rd_cnt"},  32'(rd_cnt),  32'(exp_rd));
    check({tag, ".wr_cnt"},  32'(wr_cnt),  32'(exp_wr));
    check({tag, ".err_cnt"}, 32'(err_cnt), 32'(exp_er));
`else
    check({tag, ".rd_cnt"},  32'(rd_cnt),  32'd0);
    check({tag, ".wr_cnt"},  32'(wr_cnt),  32'd0);
    check({tag, ".err_cnt"}, 32'(err_cnt), 32'd0);
`endif
  endtask

  // One full transaction: present, accept, measure latency, check response and pulse width.
  task automatic do_req(input string tag, input logic [31:0] a, input logic [31:0] d,
                        input logic [5:0] op, input logic rd, input logic wr,
                        input logic [31:0] exp_data, input logic exp_err);
    int lat;
    @(negedge clk);
    address = a; DataWrite = d; opcode = op; MemRead = rd; MemWrite = wr;
    req_valid = 1'b1;
    #1;
    check({tag, ".ready"}, 32'(req_ready), 32'd1);
    check({tag, ".stall"}, 32'(stall), 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, ".latency"}, 32'(lat), 32'd2);
    check({tag, ".data"}, ReadData, exp_data);
    check({tag, ".err"}, 32'(err), 32'(exp_err));
    if (exp_err)       exp_er++;
    else if (rd && !wr) exp_rd++;
    else if (wr && !rd) exp_wr++;
    @(posedge clk);
    #1;
    check({tag, ".pulse"}, 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; address = '0; DataWrite = '0;
    opcode = '0; MemRead = 1'b0; MemWrite = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset.ready", 32'(req_ready), 32'd1);
    check("reset.rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset.data", ReadData, 32'd0);
    check("reset.err", 32'(err), 32'd0);
    check_counters("reset");

    do_req("sw10",   32'h10, 32'hDEADBEEF, OP_SW,  1'b0, 1'b1, 32'h0,        1'b0);
    do_req("lw10",   32'h10, 32'h0,        OP_LW,  1'b1, 1'b0, 32'hDEADBEEF, 1'b0);
    do_req("sb13",   32'h13, 32'h0000007F, OP_SB,  1'b0, 1'b1, 32'h0,        1'b0);
    do_req("lb13",   32'h13, 32'h0,        OP_LB,  1'b1, 1'b0, 32'h0000007F, 1'b0);
    do_req("lbu11",  32'h11, 32'h0,        OP_LBU, 1'b1, 1'b0, 32'h000000BE, 1'b0);
    do_req("lh12",   32'h12, 32'h0,        OP_LH,  1'b1, 1'b0, 32'h00007FAD, 1'b0);
    do_req("lw12",   32'h12, 32'h0,        OP_LW,  1'b1, 1'b0, 32'h0,        1'b1);
    do_req("lw10b",  32'h10, 32'h0,        OP_LW,  1'b1, 1'b0, 32'h7FADBEEF, 1'b0);
    do_req("lb10",   32'h10, 32'h0,        OP_LB,  1'b1, 1'b0, 32'hFFFFFFEF, 1'b0);
    do_req("lh10",   32'h10, 32'h0,        OP_LH,  1'b1, 1'b0, 32'hFFFFBEEF, 1'b0);
    do_req("lhu10",  32'h10, 32'h0,        OP_LHU, 1'b1, 1'b0, 32'h0000BEEF, 1'b0);
    do_req("sh11",   32'h11, 32'h00001234, OP_SH,  1'b0, 1'b1, 32'h0,        1'b1);
    do_req("lw10c",  32'h10, 32'h0,        OP_LW,  1'b1, 1'b0, 32'h7FADBEEF, 1'b0);
    do_req("sw400",  32'h400, 32'h11223344, OP_SW, 1'b0, 1'b1, 32'h0,        1'b0);
    do_req("lw0",    32'h0,  32'h0,        OP_LW,  1'b1, 1'b0, 32'h11223344, 1'b0);
    do_req("both",   32'h0,  32'h0,        OP_LW,  1'b1, 1'b1, 32'h0,        1'b1);
    do_req("badrd",  32'h0,  32'h0,        OP_SW,  1'b1, 1'b0, 32'h0,        1'b1);
    do_req("badwr",  32'h0,  32'hFFFFFFFF, OP_LW,  1'b0, 1'b1, 32'h0,        1'b1);
    do_req("noop",   32'h0,  32'h0,        OP_LW,  1'b0, 1'b0, 32'h0,        1'b0);
    do_req("lw0b",   32'h0,  32'h0,        OP_LW,  1'b1, 1'b0, 32'h11223344, 1'b0);
    do_req("sh2",    32'h2,  32'h0000ABCD, OP_SH,  1'b0, 1'b1, 32'h0,        1'b0);
    do_req("lhu2",   32'h2,  32'h0,        OP_LHU, 1'b1, 1'b0, 32'h0000ABCD, 1'b0);
    do_req("lw0c",   32'h0,  32'h0,        OP_LW,  1'b1, 1'b0, 32'hABCD3344, 1'b0);
    check_counters("stats");

    // Reset while the store to 0x20 is still in WAIT.
    @(negedge clk);
    address = 32'h20; DataWrite = 32'hFFFFFFFF; opcode = OP_SW;
    MemRead = 1'b0; MemWrite = 1'b1; req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_rd = 0; exp_wr = 0; exp_er = 0;
    check("rstwait.ready", 32'(req_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      check("rstwait.no_rsp", 32'(rsp_valid), 32'd0);
      @(posedge clk);
      #1;
    end
    check_counters("rstwait");
    do_req("lw20",   32'h20, 32'h0,        OP_LW,  1'b1, 1'b0, 32'h0,        1'b0);
    check_counters("final");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
